// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: opcode field values, forward-select codes
// and the per-stage writer record used by the hazard unit.
package rv_pkg;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_B      = 5'b11000;
  localparam logic [4:0] OP_S      = 5'b01000;
  localparam logic [4:0] OP_I_CAL  = 5'b00100;
  localparam logic [4:0] OP_I_LOAD = 5'b00000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb;
    logic       late;
  } wr_rec_t;

  // A record only hazards a source it really writes; x0 never hazards.
  function automatic logic rec_hit(input wr_rec_t rec, input logic [4:0] rs);
    return rec.valid && rec.wb && (rec.rd != 5'd0) && (rec.rd == rs);
  endfunction

endpackage

// File: rtl/rs_hazard_unit_if.sv
// ID-side request and EX-side select bundle between the pipeline and the hazard unit.
interface rs_hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             flush;
  logic             stall;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_inst, id_valid, flush,
    input  stall, ex_fwd_a, ex_fwd_b, stall_count
  );

  modport slave (
    input  id_inst, id_valid, flush,
    output stall, ex_fwd_a, ex_fwd_b, stall_count
  );
endinterface

// File: rtl/rs_use_dec.sv
// Source-use and writer classification of one instruction.
module rs_use_dec
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        wb,
  output logic        late
);

  logic unused_bits;

  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign unused_bits = ^{inst[31:25], inst[14:12], inst[1:0]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    wb       = 1'b0;
    late     = 1'b0;
    unique case (inst[6:2])
      OP_R:      begin rs1_used = 1'b1; rs2_used = 1'b1; wb = 1'b1; end
      OP_B,
      OP_S:      begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_I_CAL:  begin rs1_used = 1'b1; wb = 1'b1; end
      OP_I_LOAD: begin rs1_used = 1'b1; wb = 1'b1; late = 1'b1; end
      OP_JALR:   begin rs1_used = 1'b1; wb = 1'b1; late = 1'b1; end
      OP_LUI,
      OP_AUIPC:  wb = 1'b1;
      OP_JAL:    begin wb = 1'b1; late = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/rs_hazard_unit.sv
// Reader-side hazard unit: load-use stall and registered EX forward selects,
// derived from its own EX/MEM writer records.
module rs_hazard_unit
  import rv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rs_hazard_unit_if.slave  bus
);

  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic             id_rs1_used, id_rs2_used, id_wb, id_late;
  logic             stall_c, load_ex_c;
  wr_rec_t          ex_q, ex_d, mem_q, mem_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rs_use_dec u_dec (
    .inst     (bus.id_inst),
    .rd       (id_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .wb       (id_wb),
    .late     (id_late)
  );

  // EX match wins; a late EX writer never reaches here because it stalls.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input wr_rec_t ex, input wr_rec_t mem);
    if (!used)             return FWD_RF;
    if (rec_hit(ex, rs))   return FWD_MEM;
    if (rec_hit(mem, rs))  return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    stall_c   = 1'b0;
    load_ex_c = 1'b0;
    ex_d      = '0;
    mem_d     = ex_q;
    fwd_a_d   = FWD_RF;
    fwd_b_d   = FWD_RF;

    stall_c = !bus.flush && bus.id_valid && ex_q.late &&
              ((id_rs1_used && rec_hit(ex_q, id_rs1)) ||
               (id_rs2_used && rec_hit(ex_q, id_rs2)));
    load_ex_c = bus.id_valid && !stall_c && !bus.flush;

    if (load_ex_c) begin
      ex_d    = '{valid: 1'b1, rd: id_rd, wb: id_wb, late: id_late};
      fwd_a_d = fwd_sel(id_rs1_used, id_rs1, ex_q, mem_q);
      fwd_b_d = fwd_sel(id_rs2_used, id_rs2, ex_q, mem_q);
    end

    cnt_d = cnt_q + CNT_W'(stall_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_rs_hazard_unit.sv
// Directed plus randomized check of rs_hazard_unit against an instruction-level pipeline model.
module tb_rs_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_hazard_unit_if #(.CNT_W(32)) bus ();

  rs_hazard_unit #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: which instructions sit in EX and MEM, and what the DUT should show.
  bit          m_ex_v, m_mem_v;
  logic [31:0] m_ex_inst, m_mem_inst;
  logic [1:0]  m_fa, m_fb;
  logic [31:0] m_cnt;

  function automatic bit uses1(input logic [31:0] i);
    case (i[6:2])
      5'b01100, 5'b11000, 5'b01000, 5'b00100, 5'b00000, 5'b11001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses2(input logic [31:0] i);
    case (i[6:2])
      5'b01100, 5'b11000, 5'b01000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] i);
    case (i[6:2])
      5'b01100, 5'b00100, 5'b00000, 5'b01101, 5'b00101, 5'b11011, 5'b11001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit slow(input logic [31:0] i);
    case (i[6:2])
      5'b00000, 5'b11011, 5'b11001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit hits(input bit v, input logic [31:0] i, input logic [4:0] r);
    return v && writes(i) && (i[11:7] != 5'd0) && (i[11:7] == r);
  endfunction

  function automatic logic [1:0] exp_sel(input bit used, input logic [4:0] r);
    if (!used) return 2'd0;
    if (hits(m_ex_v, m_ex_inst, r)) return 2'd1;
    if (hits(m_mem_v, m_mem_inst, r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ex_v = 1'b0; m_mem_v = 1'b0;
    m_ex_inst = '0; m_mem_inst = '0;
    m_fa = 2'd0; m_fb = 2'd0; m_cnt = '0;
  endtask

  // Called at a negedge: apply inputs, check stall, clock, check registered outputs.
  task automatic step(input logic [31:0] inst, input bit v, input bit fl);
    bit exp_stall, go;
    logic [1:0] na, nb;
    bus.id_inst = inst; bus.id_valid = v; bus.flush = fl;
    exp_stall = !fl && v && m_ex_v && slow(m_ex_inst) &&
                ((uses1(inst) && hits(m_ex_v, m_ex_inst, inst[19:15])) ||
                 (uses2(inst) && hits(m_ex_v, m_ex_inst, inst[24:20])));
    go = v && !exp_stall && !fl;
    na = go ? exp_sel(uses1(inst), inst[19:15]) : 2'd0;
    nb = go ? exp_sel(uses2(inst), inst[24:20]) : 2'd0;
    #1;
    chk("stall", 32'(bus.stall), 32'(exp_stall));
    @(posedge clk);
    m_mem_v = m_ex_v; m_mem_inst = m_ex_inst;
    m_ex_v = go; m_ex_inst = inst;
    m_fa = na; m_fb = nb;
    if (exp_stall) m_cnt = m_cnt + 32'd1;
    @(negedge clk);
    chk("ex_fwd_a", 32'(bus.ex_fwd_a), 32'(m_fa));
    chk("ex_fwd_b", 32'(bus.ex_fwd_b), 32'(m_fb));
    chk("stall_count", bus.stall_count, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_fwd_a", 32'(bus.ex_fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    chk("rst_count", bus.stall_count, 32'd0);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0] ops [11];
    logic [31:0] i;
    ops = '{5'b01100, 5'b11000, 5'b01000, 5'b00100, 5'b00000, 5'b11001,
            5'b01101, 5'b00101, 5'b11011, 5'b11100, 5'b00011};
    i = $urandom();
    i[6:0]   = {ops[$urandom_range(0, 10)], 2'b11};
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  localparam logic [31:0] ADD_X1   = 32'h003100B3;
  localparam logic [31:0] ADD_X4_1 = 32'h00108233;
  localparam logic [31:0] LW_X5    = 32'h00032283;
  localparam logic [31:0] ADD_X7_5 = 32'h000283B3;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] ADD_X4_0 = 32'h00000233;
  localparam logic [31:0] ADD_X4_3 = 32'h00308233;
  localparam logic [31:0] NOP      = 32'h00000013;

  initial begin
    rst = 1'b1;
    bus.id_inst = '0; bus.id_valid = 1'b0; bus.flush = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();
    step(NOP, 1'b0, 1'b0);

    // Back-to-back ALU dependency forwards from MEM.
    step(ADD_X1, 1'b1, 1'b0);
    step(ADD_X4_1, 1'b1, 1'b0);
    chk("alu_fwd_a", 32'(bus.ex_fwd_a), 32'd1);
    chk("alu_fwd_b", 32'(bus.ex_fwd_b), 32'd1);

    // Load-use: one stall, then WB forward.
    step(LW_X5, 1'b1, 1'b0);
    step(ADD_X7_5, 1'b1, 1'b0);
    chk("lu_count", bus.stall_count, 32'd1);
    step(ADD_X7_5, 1'b1, 1'b0);
    chk("lu_fwd_a", 32'(bus.ex_fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(bus.ex_fwd_b), 32'd0);

    // x0 never hazards.
    step(ADDI_X0, 1'b1, 1'b0);
    step(ADD_X4_0, 1'b1, 1'b0);
    chk("x0_fwd_a", 32'(bus.ex_fwd_a), 32'd0);

    // One and two instructions of distance.
    step(ADD_X1, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b0);
    step(ADD_X4_3, 1'b1, 1'b0);
    chk("d2_fwd_a", 32'(bus.ex_fwd_a), 32'd2);
    step(ADD_X1, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b0);
    step(ADD_X4_3, 1'b1, 1'b0);
    chk("d3_fwd_a", 32'(bus.ex_fwd_a), 32'd0);

    // Flush beats load-use stall.
    step(LW_X5, 1'b1, 1'b0);
    step(ADD_X7_5, 1'b1, 1'b1);
    chk("fl_count", bus.stall_count, 32'd1);
    chk("fl_fwd_a", 32'(bus.ex_fwd_a), 32'd0);

    // Reset in the middle of a load-use stall.
    step(LW_X5, 1'b1, 1'b0);
    bus.id_inst = ADD_X7_5; bus.id_valid = 1'b1; bus.flush = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    do_reset();
    #1;
    chk("post_rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);

    // Bubbles only.
    for (int k = 0; k < 4; k++) step(rnd_inst(), 1'b0, 1'b0);

    // Randomized traffic with dense register reuse.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(rnd_inst(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
